spi_ram: RTL and testbench

SPI_RAM -- requirements
Module: spi_ram

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_ram_if.sv | 24 ++
 rtl/spi_ram_mem.sv | 45 ++++
 rtl/spi_ram.sv | 114 +++++++++++
 tb/tb_spi_ram.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Constants and types shared by the SPI slave and the SPI-attached RAM.
//   - SPI_ADDR_SIZE / SPI_DATA_WIDTH / SPI_MEM_DEPTH : default geometry
//   - RX_DATA_WIDTH : width of one rx frame (2-bit command + address/payload)
//   - cmd_e         : command codes carried in the top two frame bits
//   - tx_state_e    : states of the RAM's transmit-hold FSM
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_ADDR_SIZE  = 8;
    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_MEM_DEPTH  = 2 ** SPI_ADDR_SIZE;
    localparam int CMD_WIDTH      = 2;
    localparam int RX_DATA_WIDTH  = SPI_ADDR_SIZE + CMD_WIDTH;

    typedef enum logic [CMD_WIDTH-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

endpackage

// File: rtl/spi_ram_if.sv
// -----------------------------------------------------------------------------
// spi_ram_if
// Link between the SPI slave (master modport) and the RAM (slave modport).
//   din      : rx frame, [ADDR_SIZE+1:ADDR_SIZE] command, [ADDR_SIZE-1:0] payload
//   rx_valid : din carries a frame this cycle
//   dout     : read data for the SPI slave to shift out
//   tx_valid : dout holds a fresh read result
//   cmd_err  : one-cycle pulse per rejected frame
// -----------------------------------------------------------------------------
interface spi_ram_if
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE  = SPI_ADDR_SIZE,
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
);
    logic [ADDR_SIZE+1:0]  din;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  cmd_err;

    modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
    modport slave  (input din, rx_valid, output dout, tx_valid, cmd_err);
endinterface

// File: rtl/spi_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_ram_mem
// MEM_DEPTH x DATA_WIDTH single-port-style array, synchronous write and
// synchronous (registered) read.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   wr_en, wr_addr, wr_data : write port, written on the rising edge
//   rd_en, rd_addr          : read request, result appears next cycle
//   rd_data                 : read register, holds until the next rd_en
// -----------------------------------------------------------------------------
module spi_ram_mem
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH  = SPI_MEM_DEPTH,
    parameter int ADDR_SIZE  = SPI_ADDR_SIZE,
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_SIZE-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros and keeps its
    // contents across rst_n; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// -----------------------------------------------------------------------------
// spi_ram
// Command-driven RAM behind an SPI slave. Decodes rx frames, keeps independent
// auto-incrementing write/read address pointers, and runs the Tx FSM that
// flags fresh read data to the SPI slave.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (memory contents are retained)
//   bus   : spi_ram_if.slave -- din/rx_valid in, dout/tx_valid/cmd_err out
// -----------------------------------------------------------------------------
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH  = SPI_MEM_DEPTH,
    parameter int ADDR_SIZE  = SPI_ADDR_SIZE,
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_ram_if.slave bus
);

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_vld;
    logic                 rd_addr_vld;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 reject;
    logic                 cmd_err_q;
    tx_state_e            state;
    tx_state_e            state_next;

    assign cmd     = cmd_e'(bus.din[ADDR_SIZE +: CMD_WIDTH]);
    assign payload = bus.din[ADDR_SIZE-1:0];

    // A data command is accepted only once its pointer has been loaded since reset.
    assign wr_accept = bus.rx_valid && (cmd == CMD_WR_DATA) && wr_addr_vld;
    assign rd_accept = bus.rx_valid && (cmd == CMD_RD_DATA) && rd_addr_vld;
    assign reject    = bus.rx_valid &&
                       (((cmd == CMD_WR_DATA) && !wr_addr_vld) ||
                        ((cmd == CMD_RD_DATA) && !rd_addr_vld));

    // Address pointers and the error pulse.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            // Re-evaluated every cycle, so each rejected frame yields exactly one pulse.
            cmd_err_q <= reject;
            if (bus.rx_valid) begin
                unique case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr     <= payload;
                        wr_addr_vld <= 1'b1;
                    end
                    CMD_WR_DATA: if (wr_addr_vld) wr_addr <= wr_addr + ADDR_SIZE'(1);
                    CMD_RD_ADDR: begin
                        rd_addr     <= payload;
                        rd_addr_vld <= 1'b1;
                    end
                    CMD_RD_DATA: if (rd_addr_vld) rd_addr <= rd_addr + ADDR_SIZE'(1);
                    default: ;
                endcase
            end
        end
    end

    // Tx FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Tx FSM next state: any frame decides HOLD vs IDLE; idle cycles keep the state.
    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        if (bus.rx_valid) begin
            state_next = rd_accept ? TX_HOLD : TX_IDLE;
        end
    end

    // The read register in the memory is dout itself: it loads only on an
    // accepted read, so it holds across TX_HOLD->TX_IDLE and reads cost one clk.
    spi_ram_mem #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rst_n && wr_accept),
        .wr_addr (wr_addr),
        .wr_data (DATA_WIDTH'(payload)),
        .rd_en   (rd_accept),
        .rd_addr (rd_addr),
        .rd_data (bus.dout)
    );

    assign bus.tx_valid = (state == TX_HOLD);
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// -----------------------------------------------------------------------------
// tb_spi_ram
// Scoreboard bench for spi_ram. The driver issues one frame (or idle/reset
// cycle) per clock, updates a frame-level model of the RAM and pushes the
// outputs that must be visible after that edge; the monitor pops and compares
// them shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_spi_ram;
    import spi_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic clk;
    logic rst_n;

    spi_ram_if #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) bus ();

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          tv;
        logic          err;
        logic [DW-1:0] dout;
        bit            dout_chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: memory as a plain array plus the two pointers.
    logic [7:0] m_mem [256];
    bit         m_written [256];
    logic [7:0] m_wa, m_ra;
    bit         m_wv, m_rv;
    logic [7:0] m_dout;
    bit         m_dout_known;
    bit         m_tv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, then predict what the DUT
    // shows after the following rising edge.
    task automatic step(input bit rst, input bit rxv, input logic [1:0] c, input logic [7:0] p);
        exp_t e;
        bit   err;
        @(negedge clk);
        rst_n        = rst;
        bus.rx_valid = rxv;
        bus.din      = {c, p};
        err          = 1'b0;
        if (!rst) begin
            m_wa = 8'h00; m_ra = 8'h00; m_wv = 0; m_rv = 0;
            m_dout = 8'h00; m_dout_known = 1; m_tv = 0;
        end else if (rxv) begin
            m_tv = 0;
            case (c)
                2'b00: begin m_wa = p; m_wv = 1; end
                2'b01: begin
                    if (m_wv) begin
                        m_mem[m_wa] = p; m_written[m_wa] = 1; m_wa = m_wa + 8'd1;
                    end else err = 1;
                end
                2'b10: begin m_ra = p; m_rv = 1; end
                default: begin
                    if (m_rv) begin
                        m_dout = m_mem[m_ra]; m_dout_known = m_written[m_ra];
                        m_ra = m_ra + 8'd1; m_tv = 1;
                    end else err = 1;
                end
            endcase
        end
        e.tv = m_tv; e.err = err; e.dout = m_dout; e.dout_chk = m_dout_known;
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [1:0] c, input logic [7:0] p);
        step(1'b1, 1'b1, c, p);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic reset_cycle();
        step(1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    // Monitor: compares the prediction for each edge just after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_valid", 32'(bus.tx_valid), 32'(e.tv));
                check("cmd_err", 32'(bus.cmd_err), 32'(e.err));
                if (e.dout_chk) check("dout", 32'(bus.dout), 32'(e.dout));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] c;
        logic [7:0] p;
        for (int i = 0; i < 256; i++) m_written[i] = 0;
        rst_n = 1'b0; bus.rx_valid = 1'b0; bus.din = '0;

        reset_cycle();
        reset_cycle();
        // Data commands before any address load are rejected, back to back.
        frame(2'b11, 8'h00);
        frame(2'b01, 8'h55);
        idle();
        // Write then read back one location.
        frame(2'b00, 8'h10); frame(2'b01, 8'hA5);
        frame(2'b10, 8'h10); frame(2'b11, 8'h00);
        idle(); idle();
        // Pointer wrap on both write and read.
        frame(2'b00, 8'hFF); frame(2'b01, 8'h11); frame(2'b01, 8'h22);
        frame(2'b10, 8'hFF); frame(2'b11, 8'h00); frame(2'b11, 8'h00);
        // Non-read frame while holding drops tx_valid, dout retained.
        frame(2'b00, 8'h05);
        idle();
        // Reset then rejected write must not touch mem[0]; read it back.
        reset_cycle();
        frame(2'b01, 8'h55);
        frame(2'b10, 8'h00); frame(2'b11, 8'h00);
        // Reset during TX_HOLD: pointers lost, memory kept.
        frame(2'b00, 8'h07); frame(2'b01, 8'h3C);
        frame(2'b10, 8'h07); frame(2'b11, 8'h00);
        reset_cycle();
        frame(2'b11, 8'h00);
        frame(2'b10, 8'h07); frame(2'b11, 8'h00);
        idle();

        // Randomized traffic, payloads biased toward a small window for reuse.
        for (int i = 0; i < 3000; i++) begin
            c = 2'($urandom_range(0, 3));
            p = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) reset_cycle();
            else if ($urandom_range(0, 6) == 0) idle();
            else frame(c, p);
        end

        idle(); idle();
        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
